bitwise_checker: RTL
====================

# bitwise_checker

Self-checking stimulus/response engine for the 4-bit bitwise logic units (AND/OR/XOR, scalar-bit ports). It drives all 256 combinations of the two nibble operands into the unit under test, samples the unit's outputs, and compares them against the expected function for the selected operation. It accumulates a mismatch count and captures the first failing vector. It sits beside the logic unit as its in-hardware checking counterpart and reports pass/fail through a done pulse.

## Interface

- SAMPLE_DELAY, 0: extra hold cycles per vector before sampling (0..3), for units with registered outputs.

- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a sweep; sampled in IDLE/DONE only.
- op  in  2  operation to check: 00 AND, 01 OR, 10 XOR, 11 reserved.
- x0, x1, x2, x3  out  1 each  first operand bits to unit.
- y0, y1, y2, y3  out  1 each  second operand bits to unit.
- o0, o1, o2, o3  in  1 each  unit outputs.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  1 when last completed sweep had zero mismatches.
- err_count  out  9  mismatching vectors in last/current sweep (0..256).
- first_fail  out  8  index of first mismatching vector.
- first_fail_valid  out  1  first_fail holds a captured index.

## Operation

- Vector index v[7:0]: x0=v[7], x1=v[6], x2=v[5], x3=v[4], y0=v[3], y1=v[2], y2=v[1], y3=v[0]. x0 is the slowest-changing bit, y3 the fastest.
- Operand outputs are registered from v.
- Expected per bit: e_i = x_i & y_i (AND), x_i | y_i (OR), x_i ^ y_i (XOR).
- A vector mismatches if any o_i != e_i. Errors are counted per vector, not per bit.
- FSM states:
  - IDLE → RUN on start with op != 11.
  - RUN → DONE after the compare of v=255.
  - DONE → RUN on start with op != 11.
- start with op = 11 is ignored in all states. start in RUN is ignored.
- On entering RUN:
  - op is latched.
  - v=0, hold counter=0, err_count=0, first_fail=0, first_fail_valid=0, pass=0.
- In RUN:
  - Each vector is held SAMPLE_DELAY+1 cycles.
  - On the last cycle of the hold, o is compared against the expected value for the currently driven v.
  - On mismatch: err_count increments. If first_fail_valid=0, then first_fail=v and first_fail_valid=1.
  - v then increments.
- Entering DONE:
  - done=1 for one cycle.
  - pass = (final err_count==0).
  - err_count, first_fail, first_fail_valid, and x/y (last vector) are held until the next start.
- err_count cannot overflow (max 256 fits 9 bits).
- latched op is unaffected by op changes during RUN.

## Timing

- Reset values: x0..x3=0, y0..y3=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0; state IDLE.
- Reset asserted mid-sweep aborts immediately to the reset values. No done pulse is produced.
- Let N=SAMPLE_DELAY+1. start accepted at edge t:
  - busy=1 and v=0 are driven from t.
  - Vector v is driven from edge t+v·N and compared at edge t+(v+1)·N.
  - At edge t+256·N: busy=0, done=1, pass valid; done clears at the next edge.
- A sweep lasts exactly 256·N cycles of busy.
- start in DONE at the same edge done is high restarts: done drops, busy rises, and the counters clear.
- The unit under test is combinational for SAMPLE_DELAY=0. Outputs must be stable before the compare edge.

## Test plan

- AND unit, op=00, SAMPLE_DELAY=0, pulse start → busy for 256 cycles, done pulse, pass=1, err_count=0, first_fail_valid=0.
- AND unit, op=10 (XOR check) → err_count=255, first_fail=8'h01, first_fail_valid=1, pass=0.
- OR unit with o2 forced 0, op=01 → err_count=192, first_fail=8'h02, pass=0.
- start with op=11 from IDLE → busy stays 0, no done, all outputs remain at reset values.
- Sweep AND, assert reset when v=100 → all outputs zero immediately; new start yields a full 256-cycle sweep with pass=1.
- SAMPLE_DELAY=2, AND unit with one-cycle output register, op=00 → done 768 cycles after start, pass=1. start pulses during RUN are ignored (sweep length unchanged).

Source files
------------

// File: rtl/bitwise_checker.sv
// In-hardware sweep checker for 4-bit bitwise logic units: drives all 256
// operand pairs, compares the unit's outputs and reports mismatches.
module bitwise_checker #(
   parameter int unsigned SAMPLE_DELAY = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] op,
   output logic       x0,
   output logic       x1,
   output logic       x2,
   output logic       x3,
   output logic       y0,
   output logic       y1,
   output logic       y2,
   output logic       y3,
   input  logic       o0,
   input  logic       o1,
   input  logic       o2,
   input  logic       o3,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [8:0] err_count,
   output logic [7:0] first_fail,
   output logic       first_fail_valid
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [1:0] HOLD_LAST = 2'(SAMPLE_DELAY);
   localparam logic [1:0] OP_AND    = 2'b00;
   localparam logic [1:0] OP_OR     = 2'b01;
   localparam logic [1:0] OP_RSVD   = 2'b11;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [7:0]  v_q, v_d;
   logic [1:0]  hold_q, hold_d;
   logic [8:0]  err_q, err_d;
   logic [7:0]  ff_q, ff_d;
   logic        ffv_q, ffv_d;
   logic        pass_q, pass_d;
   logic        done_q, done_d;

   logic [3:0]  x_vec, y_vec, o_vec, e_vec;
   logic        mismatch;

   // Bit i of each nibble vector corresponds to port x_i / y_i / o_i.
   always_comb begin
      x_vec = {v_q[4], v_q[5], v_q[6], v_q[7]};
      y_vec = {v_q[0], v_q[1], v_q[2], v_q[3]};
      o_vec = {o3, o2, o1, o0};
      e_vec = '0;
      case (op_q)
         OP_AND:  e_vec = x_vec & y_vec;
         OP_OR:   e_vec = x_vec | y_vec;
         default: e_vec = x_vec ^ y_vec;
      endcase
      mismatch = (o_vec != e_vec);
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      v_d     = v_q;
      hold_d  = hold_q;
      err_d   = err_q;
      ff_d    = ff_q;
      ffv_d   = ffv_q;
      pass_d  = pass_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start && (op != OP_RSVD)) begin
               state_d = S_RUN;
               op_d    = op;
               v_d     = '0;
               hold_d  = '0;
               err_d   = '0;
               ff_d    = '0;
               ffv_d   = 1'b0;
               pass_d  = 1'b0;
            end
         end
         S_RUN: begin
            if (hold_q == HOLD_LAST) begin
               if (mismatch) begin
                  err_d = err_q + 9'd1;
                  if (!ffv_q) begin
                     ff_d  = v_q;
                     ffv_d = 1'b1;
                  end
               end
               // The last vector stays on the operand ports after the sweep.
               if (v_q == 8'hff) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 9'd0);
               end else begin
                  v_d    = v_q + 8'd1;
                  hold_d = '0;
               end
            end else begin
               hold_d = hold_q + 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         v_q     <= '0;
         hold_q  <= '0;
         err_q   <= '0;
         ff_q    <= '0;
         ffv_q   <= 1'b0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         v_q     <= v_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         ffv_q   <= ffv_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
      end
   end

   assign x0 = v_q[7];
   assign x1 = v_q[6];
   assign x2 = v_q[5];
   assign x3 = v_q[4];
   assign y0 = v_q[3];
   assign y1 = v_q[2];
   assign y2 = v_q[1];
   assign y3 = v_q[0];

   assign busy             = (state_q == S_RUN);
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail       = ff_q;
   assign first_fail_valid = ffv_q;

endmodule
